// File: rtl/apb_master_nsel_pkg.sv
// Shared types and width helpers for the multi-slave APB3 master.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic valid;
        logic err;
    } rsp_flags_t;

    function automatic int selWidth(input int nslave);
        return (nslave <= 1) ? 1 : $clog2(nslave);
    endfunction

    // A zero timeout still needs a one-bit counter so the logic stays well formed.
    function automatic int cntWidth(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_nsel_if.sv
// Command/response port plus APB3 segment signals of the multi-slave master.
interface apb_master_nsel_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int NSLAVE = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [AWIDTH-1:0]        cmd_addr;
    logic [DWIDTH-1:0]        cmd_wdata;
    logic                     rsp_valid;
    logic [DWIDTH-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic [NSLAVE-1:0]        PSEL;
    logic                     PENABLE;
    logic                     PWRITE;
    logic [AWIDTH-1:0]        PADDR;
    logic [DWIDTH-1:0]        PWDATA;
    logic [NSLAVE*DWIDTH-1:0] PRDATA;
    logic [NSLAVE-1:0]        PREADY;
    logic [NSLAVE-1:0]        PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_master_nsel_decode.sv
// Maps the top address bits to a slave index, a one-hot select and an out-of-range flag.
module apb_slave_decode
    import apb_master_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int NSLAVE = 4
) (
    input  logic [AWIDTH-1:0]                 addr_i,
    output logic [selWidth(NSLAVE)-1:0]       index_o,
    output logic [NSLAVE-1:0]                 onehot_o,
    output logic                              oorange_o
);
    localparam int SELW = selWidth(NSLAVE);

    logic unusedAddrBits;

    assign unusedAddrBits = ^addr_i[AWIDTH-SELW-1:0];
    assign index_o        = addr_i[AWIDTH-1 -: SELW];
    assign oorange_o      = (32'(index_o) >= 32'(NSLAVE));

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            onehot_o[i] = (32'(index_o) == 32'(i));
        end
    end

endmodule

// File: rtl/apb_master_nsel.sv
// APB3 master: one command at a time, SETUP/ACCESS to a decoded slave, registered
// response strobe with an optional wait-state timeout.
module apb_master_nsel
    import apb_master_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter int NSLAVE  = 4,
    parameter int TIMEOUT = 16
) (
    input logic               PCLK,
    input logic               PRESETn,
    apb_master_nsel_if.master bus
);
    localparam int SELW = selWidth(NSLAVE);
    localparam int CW   = cntWidth(TIMEOUT);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    apb_state_e        state_q, state_d;
    logic [SELW-1:0]   index_q, index_d;
    logic [NSLAVE-1:0] oneHot_q, oneHot_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DWIDTH-1:0] pwdata_q, pwdata_d;
    logic [CW-1:0]     waitCnt_q, waitCnt_d;
    rsp_flags_t        rsp_q, rsp_d;
    logic [DWIDTH-1:0] rspRdata_q, rspRdata_d;

    logic [SELW-1:0]   decIndex;
    logic [NSLAVE-1:0] decOnehot;
    logic              decOutOfRange;
    logic [CW-1:0]     waitSat;
    logic              selReady;
    logic              selErr;
    logic [DWIDTH-1:0] selData;

    apb_slave_decode #(
        .AWIDTH (AWIDTH),
        .NSLAVE (NSLAVE)
    ) u_decode (
        .addr_i    (bus.cmd_addr),
        .index_o   (decIndex),
        .onehot_o  (decOnehot),
        .oorange_o (decOutOfRange)
    );

    assign waitSat = (&waitCnt_q) ? waitCnt_q : waitCnt_q + 1'b1;

    // Only the latched slave's completion signals are ever looked at.
    always_comb begin
        selReady = 1'b0;
        selErr   = 1'b0;
        selData  = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (32'(index_q) == 32'(i)) begin
                selReady = bus.PREADY[i];
                selErr   = bus.PSLVERR[i];
                selData  = bus.PRDATA[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        oneHot_d   = oneHot_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        waitCnt_d  = waitCnt_q;
        rsp_d      = '0;
        rspRdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (decOutOfRange) begin
                        rsp_d = '{valid: 1'b1, err: 1'b1};
                    end else begin
                        state_d   = SETUP;
                        index_d   = decIndex;
                        oneHot_d  = decOnehot;
                        paddr_d   = bus.cmd_addr;
                        pwrite_d  = bus.cmd_write;
                        pwdata_d  = bus.cmd_wdata;
                        waitCnt_d = '0;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (selReady) begin
                    state_d    = IDLE;
                    rsp_d      = '{valid: 1'b1, err: selErr};
                    rspRdata_d = (!pwrite_q && !selErr) ? selData : '0;
                end else begin
                    waitCnt_d = waitSat;
                    if ((TIMEOUT != 0) && (waitSat == TO_VAL)) begin
                        state_d = IDLE;
                        rsp_d   = '{valid: 1'b1, err: 1'b1};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            index_q    <= '0;
            oneHot_q   <= '0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            waitCnt_q  <= '0;
            rsp_q      <= '0;
            rspRdata_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            oneHot_q   <= oneHot_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            waitCnt_q  <= waitCnt_d;
            rsp_q      <= rsp_d;
            rspRdata_q <= rspRdata_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.PSEL      = (state_q == IDLE) ? '0 : oneHot_q;
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_q.valid;
    assign bus.rsp_err   = rsp_q.err;
    assign bus.rsp_rdata = rspRdata_q;

endmodule

// File: doc/apb_master_nsel.md
# apb_master_nsel

Parametrised, synchronous successor to the handshake-only APB master. It accepts one command at a time on a valid/ready port and drives a full APB3 transfer (SETUP then ACCESS) to one of NSLAVE slaves selected by upper address bits. It returns read data and an error flag on a one-cycle response strobe, with a wait-state timeout. It sits between the bus-fabric command source and the peripheral APB segment.

## Interface
- DWIDTH, 32, data width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
- AWIDTH, 32, address width
- NSLAVE, 4, number of PSEL lines (1..16); SELW = max(1, $clog2(NSLAVE))
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
- PCLK  in  1  bus clock; all state changes on rising edge
- PRESETn  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AWIDTH  byte address; slave index = cmd_addr[AWIDTH-1 -: SELW]
- cmd_wdata  in  DWIDTH  write data
- rsp_valid  out  1  one-cycle response strobe (no backpressure)
- rsp_rdata  out  DWIDTH  read data (0 for writes and errors)
- rsp_err  out  1  PSLVERR, decode error or timeout
- PSEL  out  NSLAVE  one-hot slave select
- PENABLE  out  1  ACCESS phase
- PWRITE  out  1  direction
- PADDR  out  AWIDTH  address
- PWDATA  out  DWIDTH  write data
- PRDATA  in  NSLAVE*DWIDTH  slave i read data at [i*DWIDTH +: DWIDTH]
- PREADY  in  NSLAVE  per-slave ready
- PSLVERR  in  NSLAVE  per-slave error

## Operation
- States: IDLE, SETUP, ACCESS. Reset -> IDLE.
- cmd_ready = 1 only in IDLE. Accept = cmd_valid & cmd_ready at a PCLK edge.
- Accept, index < NSLAVE: latch cmd into PADDR/PWRITE/PWDATA and index; -> SETUP.
- Accept, index >= NSLAVE: no APB activity; rsp_valid=1, rsp_err=1, rsp_rdata=0 registered at the accept edge; stay IDLE.
- SETUP: PSEL[index]=1, PENABLE=0; -> ACCESS unconditionally.
- ACCESS: PSEL[index]=1, PENABLE=1. Only PREADY/PSLVERR/PRDATA of the selected slave are observed; others are ignored.
  - PREADY[index]=1: register rsp_valid=1, rsp_err=PSLVERR[index], rsp_rdata = read & !PSLVERR ? PRDATA slice : 0; -> IDLE.
  - else, wait counter increments; when it reaches TIMEOUT (TIMEOUT>0): rsp_valid=1, rsp_err=1, rsp_rdata=0; -> IDLE.
- Wait counter: width $clog2(TIMEOUT+1), cleared on entry to SETUP, saturates, never wraps.
- PADDR/PWRITE/PWDATA stable from SETUP through completion; hold last value in IDLE.
- Reset outputs: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, cmd_ready=1 (IDLE), rsp_valid=0, rsp_err=0, rsp_rdata=0.
- Reset mid-transfer: everything clears immediately, no response produced.

## Timing
- All outputs registered or decoded from state/registers only. No combinational path from PREADY/PRDATA/cmd_valid to any output.
- Zero-wait transfer accepted at edge T: SETUP in cycle T..T+1, ACCESS in T+1..T+2, rsp_valid high T+2..T+3, cmd_ready high again from T+2.
- Minimum throughput: one transfer per 3 cycles, with cmd_valid held.
- N wait states add N cycles to the above.
- Timeout with TIMEOUT=k: rsp_valid asserts k cycles after ACCESS entry; PSEL/PENABLE drop in the same cycle.
- Decode error: rsp_valid in the cycle after accept; next command may be accepted at the following edge.

## Structure
- Package apb_master_pkg: state enum (IDLE/SETUP/ACCESS), SELW computation function, response field struct.
- One sub-module, apb_slave_decode: cmd_addr -> index, one-hot select, out-of-range flag; purely combinational, parametrised by AWIDTH/NSLAVE.

## Test plan
- Read slave 2, no wait, PRDATA[2]=0xCAFE_F00D -> PSEL=4'b0100 for 2 cycles, PENABLE in the second only, rsp_valid 1 cycle, rsp_rdata=0xCAFE_F00D, rsp_err=0.
- Write slave 0 to 0x0000_0010, data 0x1234_5678, PREADY[0] low 3 cycles -> PADDR/PWDATA stable for 5 cycles, rsp_valid at T+5, rsp_err=0.
- Read slave 1 with PSLVERR[1]=1 on the completing cycle -> rsp_err=1, rsp_rdata=0; PREADY on slave 3 during the transfer ignored.
- NSLAVE=3, address index 3 -> PSEL stays 0, rsp_valid+rsp_err the next cycle, cmd_ready never drops.
- TIMEOUT=4, PREADY held low -> PSEL/PENABLE drop and rsp_err=1 exactly 4 cycles after ACCESS entry; back-to-back commands then proceed normally.
- PRESETn pulsed low during ACCESS -> all outputs at reset values asynchronously, no rsp_valid, next command completes correctly.
